stack_sequencer: RTL and testbench
==================================

STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 The block SHALL take parameter PC_WORDS, default 2, the number of 16-bit stack words per saved PC (legal range 1..4).
REQ-002 The block SHALL take parameter POP_WAIT, default 2, the number of idle cycles inserted before the first pop of ret/rti (legal range 0..3).
REQ-003 The block SHALL take parameter IRQ_DEFER, default 1, the number of extra cycles an accepted interrupt waits when ldm or load_use is high at acceptance (legal range 0..3).
REQ-004 Derived width SELW SHALL equal clog2(PC_WORDS+2).
REQ-005 Ports SHALL be:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- call, ret, rti  in  1 each  decoded opcode strobes
- irq  in  1  external interrupt, level or pulse
- ldm, load_use  in  1 each  pipeline hazard indicators
- irq_ack  out  1  one-cycle interrupt acceptance pulse
- busy  out  1  sequence in progress
- stack, mem_wr, mem_rd  out  1 each  SP-addressed access, write, read
- push_sel  out  SELW  write-data source: 0 = normal, i = PC word i, PC_WORDS+1 = CCR
- pop_sel  out  SELW  read-data destination, same encoding
- freeze_pc, freeze_cu  out  1 each  fetch and decode stall
- pc_sel  out  2  00 = PC+1, 01 = stack, 10 = vector, 11 = call target
- flush  out  1  squash younger pipeline stages

Function
REQ-006 States SHALL be IDLE, IRQ_WAIT, IRQ_FRZ, PUSH, PWAIT, POP; a word counter (0..PC_WORDS) and a wait counter (0..3) SHALL be registered.
REQ-007 All outputs SHALL be decoded from registered state only (Moore); a request sampled at edge k affects outputs from cycle k+1.
REQ-008 irq high at any edge SHALL set irq_pending; irq_pending SHALL clear only on interrupt acceptance.
REQ-009 In IDLE, acceptance priority SHALL be rti > ret > call > irq_pending; at most one request is accepted per edge, and non-winning call/ret/rti strobes are dropped.
REQ-010 While busy=1, call/ret/rti SHALL be ignored; irq still sets irq_pending.
REQ-011 Call SHALL move to PUSH for PC_WORDS cycles: push_sel = 1..PC_WORDS in ascending order, stack=mem_wr=1, and no freeze; the final push cycle SHALL assert pc_sel=11 and flush=1; the next state is IDLE.
REQ-012 Interrupt acceptance SHALL pulse irq_ack for exactly the cycle after the accepting edge.
REQ-013 On acceptance, the sequencer SHALL enter IRQ_WAIT for 1 cycle, plus IRQ_DEFER cycles if ldm or load_use was high at the accepting edge.
REQ-014 After IRQ_WAIT, the sequencer SHALL enter IRQ_FRZ for 1 cycle with freeze_pc=1.
REQ-015 After IRQ_FRZ, the sequencer SHALL enter PUSH for PC_WORDS+1 cycles: push_sel = 1..PC_WORDS, then PC_WORDS+1 (CCR); freeze_pc=freeze_cu=1 and stack=mem_wr=1 throughout; pc_sel=10 on the CCR cycle only.
REQ-016 Ret SHALL run PWAIT for POP_WAIT cycles (busy=1, all other outputs 0), then POP for PC_WORDS cycles: pop_sel = PC_WORDS down to 1, mem_rd=stack=freeze_pc=freeze_cu=1; the final pop SHALL assert pc_sel=01 and flush=1.
REQ-017 Rti SHALL behave as ret, except that POP SHALL first issue pop_sel=PC_WORDS+1 (CCR), giving PC_WORDS+1 pop cycles.
REQ-018 With POP_WAIT=0, POP SHALL begin the cycle after acceptance.
REQ-019 Total busy cycles SHALL be:
- call: PC_WORDS
- irq: PC_WORDS+3 (+IRQ_DEFER if deferred)
- ret: POP_WAIT+PC_WORDS
- rti: POP_WAIT+PC_WORDS+1
REQ-020 On the terminating cycle, the next state SHALL be IDLE; a pending irq or a new strobe SHALL be accepted at the following edge, with no dead cycle beyond that.
REQ-021 In IDLE, every output SHALL be 0.
REQ-022 pc_sel and flush SHALL never be non-zero outside the cycles named in REQ-011, REQ-015, REQ-016 and REQ-017.
REQ-023 mem_wr and mem_rd SHALL never be high in the same cycle.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE and clear both counters and irq_pending, including mid-sequence; the sequence is aborted with no further push or pop.
REQ-025 During and after reset, all outputs SHALL be 0 from the cycle after the reset edge.
REQ-026 A request coincident with rst SHALL be discarded.

Verification (PC_WORDS=2, POP_WAIT=2, IRQ_DEFER=1)
REQ-027 call pulse at edge 0 -> cycles 1-2 push_sel=1,2 with mem_wr=stack=1; cycle 2 pc_sel=11 and flush=1; cycle 3 all 0.
REQ-028 irq with ldm=1 at edge 0 -> irq_ack=1 in cycle 1; IRQ_WAIT cycles 1-2; freeze_pc=1 in cycle 3; push_sel=1,2,3 in cycles 4-6 with pc_sel=10 in cycle 6; busy for 6 cycles.
REQ-029 rti at edge 0 -> cycles 1-2 idle-busy; cycles 3-5 pop_sel=3,2,1 with mem_rd=1; cycle 5 pc_sel=01 and flush=1.
REQ-030 call, ret and irq in the same cycle -> ret sequence runs; irq_ack follows in the cycle after the ret sequence ends; call is never executed.
REQ-031 rst asserted in the second push cycle of an interrupt -> all outputs 0 the next cycle; irq_pending cleared; no CCR push occurs.
REQ-032 irq pulse during a call sequence -> latched; irq_ack in the first cycle after busy falls.

Source files
------------

// File: rtl/stack_sequencer_if.sv
// Request/response bundle between the decode stage and the stack sequencer.
// The master side issues opcode strobes and hazard flags; the slave side returns the stack and pipeline controls.
interface stack_sequencer_if #(
    parameter int SELW = 2
);
    logic            call;
    logic            ret;
    logic            rti;
    logic            irq;
    logic            ldm;
    logic            load_use;
    logic            irq_ack;
    logic            busy;
    logic            stack;
    logic            mem_wr;
    logic            mem_rd;
    logic [SELW-1:0] push_sel;
    logic [SELW-1:0] pop_sel;
    logic            freeze_pc;
    logic            freeze_cu;
    logic [1:0]      pc_sel;
    logic            flush;

    modport master (
        output call, ret, rti, irq, ldm, load_use,
        input  irq_ack, busy, stack, mem_wr, mem_rd, push_sel, pop_sel,
               freeze_pc, freeze_cu, pc_sel, flush
    );

    modport slave (
        input  call, ret, rti, irq, ldm, load_use,
        output irq_ack, busy, stack, mem_wr, mem_rd, push_sel, pop_sel,
               freeze_pc, freeze_cu, pc_sel, flush
    );
endinterface

// File: rtl/stack_sequencer.sv
// Call/return/interrupt stack sequencer: saves and restores the PC (and CCR on interrupts)
// over several stack cycles while stalling fetch/decode. Outputs are registered Moore decodes.
module stack_sequencer #(
    parameter int PC_WORDS  = 2,
    parameter int POP_WAIT  = 2,
    parameter int IRQ_DEFER = 1
) (
    input  logic              clk,
    input  logic              rst,
    stack_sequencer_if.slave  bus
);
    localparam int SELW = $clog2(PC_WORDS + 2);

    localparam logic [SELW-1:0] SEL_ONE   = SELW'(1);
    localparam logic [SELW-1:0] SEL_LAST  = SELW'(PC_WORDS);
    localparam logic [SELW-1:0] SEL_CCR   = SELW'(PC_WORDS + 1);
    localparam logic [1:0]      DEFER_CNT = 2'(IRQ_DEFER);
    localparam logic [1:0]      PWAIT_CNT = 2'((POP_WAIT > 0) ? (POP_WAIT - 1) : 0);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IRQ_WAIT = 3'd1,
        IRQ_FRZ  = 3'd2,
        PUSH     = 3'd3,
        PWAIT    = 3'd4,
        POP      = 3'd5
    } state_t;

    localparam state_t RET_START = (POP_WAIT == 0) ? POP : PWAIT;

    typedef struct packed {
        logic            irq_ack;
        logic            busy;
        logic            stack;
        logic            mem_wr;
        logic            mem_rd;
        logic [SELW-1:0] push_sel;
        logic [SELW-1:0] pop_sel;
        logic            freeze_pc;
        logic            freeze_cu;
        logic [1:0]      pc_sel;
        logic            flush;
    } out_t;

    state_t          state_r,       state_s;
    logic [SELW-1:0] word_cnt_r,    word_cnt_s;
    logic [1:0]      wait_cnt_r,    wait_cnt_s;
    logic            ccr_r,         ccr_s;
    logic            irq_seq_r,     irq_seq_s;
    logic            irq_pending_r, irq_pending_s;
    logic            accept_irq_s;
    out_t            out_r;

    // ccr marks the CCR word slot: last push of an interrupt, first pop of rti.
    function automatic out_t decode(input state_t st, input logic [SELW-1:0] wc,
                                    input logic ccr, input logic irq_seq, input logic ack);
        out_t o;
        o         = '0;
        o.irq_ack = ack;
        case (st)
            IDLE: begin
                o.irq_ack = 1'b0;
            end
            IRQ_WAIT, PWAIT: begin
                o.busy = 1'b1;
            end
            IRQ_FRZ: begin
                o.busy      = 1'b1;
                o.freeze_pc = 1'b1;
            end
            PUSH: begin
                o.busy     = 1'b1;
                o.stack    = 1'b1;
                o.mem_wr   = 1'b1;
                o.push_sel = ccr ? SEL_CCR : wc;
                if (irq_seq) begin
                    o.freeze_pc = 1'b1;
                    o.freeze_cu = 1'b1;
                    o.pc_sel    = ccr ? 2'b10 : 2'b00;
                end else if (wc == SEL_LAST) begin
                    o.pc_sel = 2'b11;
                    o.flush  = 1'b1;
                end else begin
                    o.pc_sel = 2'b00;
                end
            end
            POP: begin
                o.busy      = 1'b1;
                o.stack     = 1'b1;
                o.mem_rd    = 1'b1;
                o.freeze_pc = 1'b1;
                o.freeze_cu = 1'b1;
                o.pop_sel   = ccr ? SEL_CCR : wc;
                if (!ccr && (wc == SEL_ONE)) begin
                    o.pc_sel = 2'b01;
                    o.flush  = 1'b1;
                end else begin
                    o.pc_sel = 2'b00;
                end
            end
            default: begin
                o = '0;
            end
        endcase
        return o;
    endfunction

    // Next-state logic: request arbitration in IDLE and word/wait counting elsewhere.
    always_comb begin
        state_s       = state_r;
        word_cnt_s    = word_cnt_r;
        wait_cnt_s    = wait_cnt_r;
        ccr_s         = ccr_r;
        irq_seq_s     = irq_seq_r;
        irq_pending_s = irq_pending_r | bus.irq;
        accept_irq_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.rti || bus.ret) begin
                    state_s    = RET_START;
                    word_cnt_s = SEL_LAST;
                    wait_cnt_s = PWAIT_CNT;
                    ccr_s      = bus.rti;
                    irq_seq_s  = 1'b0;
                end else if (bus.call) begin
                    state_s    = PUSH;
                    word_cnt_s = SEL_ONE;
                    ccr_s      = 1'b0;
                    irq_seq_s  = 1'b0;
                end else if (irq_pending_s) begin
                    state_s       = IRQ_WAIT;
                    accept_irq_s  = 1'b1;
                    irq_pending_s = 1'b0;
                    wait_cnt_s    = (bus.ldm || bus.load_use) ? DEFER_CNT : 2'd0;
                    ccr_s         = 1'b0;
                    irq_seq_s     = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            IRQ_WAIT: begin
                if (wait_cnt_r == 2'd0) begin
                    state_s = IRQ_FRZ;
                end else begin
                    wait_cnt_s = wait_cnt_r - 2'd1;
                end
            end
            IRQ_FRZ: begin
                state_s    = PUSH;
                word_cnt_s = SEL_ONE;
            end
            PUSH: begin
                if (ccr_r) begin
                    state_s = IDLE;
                    ccr_s   = 1'b0;
                end else if (word_cnt_r == SEL_LAST) begin
                    if (irq_seq_r) begin
                        ccr_s = 1'b1;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    word_cnt_s = word_cnt_r + SEL_ONE;
                end
            end
            PWAIT: begin
                if (wait_cnt_r == 2'd0) begin
                    state_s    = POP;
                    word_cnt_s = SEL_LAST;
                end else begin
                    wait_cnt_s = wait_cnt_r - 2'd1;
                end
            end
            POP: begin
                if (ccr_r) begin
                    ccr_s = 1'b0;
                end else if (word_cnt_r == SEL_ONE) begin
                    state_s = IDLE;
                end else begin
                    word_cnt_s = word_cnt_r - SEL_ONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and the registered output decode of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            word_cnt_r    <= '0;
            wait_cnt_r    <= 2'd0;
            ccr_r         <= 1'b0;
            irq_seq_r     <= 1'b0;
            irq_pending_r <= 1'b0;
            out_r         <= '0;
        end else begin
            state_r       <= state_s;
            word_cnt_r    <= word_cnt_s;
            wait_cnt_r    <= wait_cnt_s;
            ccr_r         <= ccr_s;
            irq_seq_r     <= irq_seq_s;
            irq_pending_r <= irq_pending_s;
            out_r         <= decode(state_s, word_cnt_s, ccr_s, irq_seq_s, accept_irq_s);
        end
    end

    assign bus.irq_ack   = out_r.irq_ack;
    assign bus.busy      = out_r.busy;
    assign bus.stack     = out_r.stack;
    assign bus.mem_wr    = out_r.mem_wr;
    assign bus.mem_rd    = out_r.mem_rd;
    assign bus.push_sel  = out_r.push_sel;
    assign bus.pop_sel   = out_r.pop_sel;
    assign bus.freeze_pc = out_r.freeze_pc;
    assign bus.freeze_cu = out_r.freeze_cu;
    assign bus.pc_sel    = out_r.pc_sel;
    assign bus.flush     = out_r.flush;
endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer (PC_WORDS=2, POP_WAIT=2, IRQ_DEFER=1) with hand-computed
// per-cycle output vectors {ack,busy,stack,wr,rd,push_sel,pop_sel,frz_pc,frz_cu,pc_sel,flush}.
module tb_stack_sequencer;
    logic clk;
    logic rst;
    int   check_cnt;
    int   pass_cnt;

    stack_sequencer_if #(.SELW(2)) bus ();

    stack_sequencer #(
        .PC_WORDS (2),
        .POP_WAIT (2),
        .IRQ_DEFER(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    logic [13:0] obs;
    assign obs = {bus.irq_ack, bus.busy, bus.stack, bus.mem_wr, bus.mem_rd, bus.push_sel,
                  bus.pop_sel, bus.freeze_pc, bus.freeze_cu, bus.pc_sel, bus.flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [13:0] ev(input int ack, input int busy, input int stk, input int wr,
                                       input int rd, input int push, input int pop, input int fpc,
                                       input int fcu, input int pcs, input int fl);
        return {1'(ack), 1'(busy), 1'(stk), 1'(wr), 1'(rd), 2'(push), 2'(pop),
                1'(fpc), 1'(fcu), 2'(pcs), 1'(fl)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [13:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    initial begin
        logic [13:0] zero_v, call1_v, call2_v, wait_v, frz_v, ipush1_v, ipush2_v, ipush3_v;
        logic [13:0] ack_v, pop3_v, pop2_v, pop1_v;
        zero_v   = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        call1_v  = ev(0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
        call2_v  = ev(0, 1, 1, 1, 0, 2, 0, 0, 0, 3, 1);
        ack_v    = ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        wait_v   = ev(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        frz_v    = ev(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        ipush1_v = ev(0, 1, 1, 1, 0, 1, 0, 1, 1, 0, 0);
        ipush2_v = ev(0, 1, 1, 1, 0, 2, 0, 1, 1, 0, 0);
        ipush3_v = ev(0, 1, 1, 1, 0, 3, 0, 1, 1, 2, 0);
        pop3_v   = ev(0, 1, 1, 0, 1, 0, 3, 1, 1, 0, 0);
        pop2_v   = ev(0, 1, 1, 0, 1, 0, 2, 1, 1, 0, 0);
        pop1_v   = ev(0, 1, 1, 0, 1, 0, 1, 1, 1, 1, 1);

        check_cnt    = 0;
        pass_cnt     = 0;
        rst          = 1'b1;
        bus.call     = 1'b0;
        bus.ret      = 1'b0;
        bus.rti      = 1'b0;
        bus.irq      = 1'b0;
        bus.ldm      = 1'b0;
        bus.load_use = 1'b0;
        tick();
        tick();
        chk("reset_state", zero_v);
        rst = 1'b0;
        tick();
        chk("idle_after_reset", zero_v);

        // call
        bus.call = 1'b1;
        tick();
        bus.call = 1'b0;
        chk("call_c1", call1_v);
        tick(); chk("call_c2", call2_v);
        tick(); chk("call_c3", zero_v);

        // irq with ldm: deferred by one cycle
        bus.irq = 1'b1;
        bus.ldm = 1'b1;
        tick();
        bus.irq = 1'b0;
        bus.ldm = 1'b0;
        chk("irqd_c1_ack", ack_v);
        tick(); chk("irqd_c2_wait", wait_v);
        tick(); chk("irqd_c3_frz", frz_v);
        tick(); chk("irqd_c4_push1", ipush1_v);
        tick(); chk("irqd_c5_push2", ipush2_v);
        tick(); chk("irqd_c6_ccr", ipush3_v);
        tick(); chk("irqd_c7_idle", zero_v);

        // irq with load_use held low: no deferral
        bus.irq = 1'b1;
        tick();
        bus.irq = 1'b0;
        chk("irq_c1_ack", ack_v);
        tick(); chk("irq_c2_frz", frz_v);
        tick(); chk("irq_c3_push1", ipush1_v);
        tick(); chk("irq_c4_push2", ipush2_v);
        tick(); chk("irq_c5_ccr", ipush3_v);
        tick(); chk("irq_c6_idle", zero_v);

        // rti
        bus.rti = 1'b1;
        tick();
        bus.rti = 1'b0;
        chk("rti_c1_wait", wait_v);
        tick(); chk("rti_c2_wait", wait_v);
        tick(); chk("rti_c3_pop_ccr", pop3_v);
        tick(); chk("rti_c4_pop2", pop2_v);
        tick(); chk("rti_c5_pop1", pop1_v);
        tick(); chk("rti_c6_idle", zero_v);

        // call + ret + irq together: ret wins, irq follows, call dropped
        bus.call = 1'b1;
        bus.ret  = 1'b1;
        bus.irq  = 1'b1;
        tick();
        bus.call = 1'b0;
        bus.ret  = 1'b0;
        bus.irq  = 1'b0;
        chk("prio_c1_wait", wait_v);
        tick(); chk("prio_c2_wait", wait_v);
        tick(); chk("prio_c3_pop2", pop2_v);
        tick(); chk("prio_c4_pop1", pop1_v);
        tick(); chk("prio_c5_idle", zero_v);
        tick(); chk("prio_c6_ack", ack_v);
        tick(); chk("prio_c7_frz", frz_v);
        tick(); chk("prio_c8_push1", ipush1_v);
        tick(); chk("prio_c9_push2", ipush2_v);
        tick(); chk("prio_c10_ccr", ipush3_v);
        tick(); chk("prio_c11_idle", zero_v);

        // reset during the second interrupt push cycle
        bus.irq = 1'b1;
        tick();
        bus.irq = 1'b0;
        chk("rsti_c1_ack", ack_v);
        tick(); chk("rsti_c2_frz", frz_v);
        tick(); chk("rsti_c3_push1", ipush1_v);
        tick(); chk("rsti_c4_push2", ipush2_v);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rsti_c5_reset", zero_v);
        tick(); chk("rsti_c6_no_ccr", zero_v);
        tick(); chk("rsti_c7_no_pending", zero_v);

        // irq pulse during a call sequence is latched
        bus.call = 1'b1;
        tick();
        bus.call = 1'b0;
        chk("cirq_c1", call1_v);
        bus.irq = 1'b1;
        tick();
        bus.irq = 1'b0;
        chk("cirq_c2", call2_v);
        tick(); chk("cirq_c3_idle", zero_v);
        tick(); chk("cirq_c4_ack", ack_v);
        tick(); chk("cirq_c5_frz", frz_v);
        tick(); chk("cirq_c6_push1", ipush1_v);
        tick(); chk("cirq_c7_push2", ipush2_v);
        tick(); chk("cirq_c8_ccr", ipush3_v);
        tick(); chk("cirq_c9_idle", zero_v);

        // request coincident with reset is discarded
        rst      = 1'b1;
        bus.call = 1'b1;
        tick();
        rst      = 1'b0;
        bus.call = 1'b0;
        chk("rstreq_c1", zero_v);
        tick(); chk("rstreq_c2", zero_v);

        // strobes while busy are ignored
        bus.ret = 1'b1;
        tick();
        bus.ret = 1'b0;
        chk("busy_c1_wait", wait_v);
        bus.rti  = 1'b1;
        bus.call = 1'b1;
        tick();
        bus.rti  = 1'b0;
        bus.call = 1'b0;
        chk("busy_c2_wait", wait_v);
        tick(); chk("busy_c3_pop2", pop2_v);
        tick(); chk("busy_c4_pop1", pop1_v);
        tick(); chk("busy_c5_idle", zero_v);
        tick(); chk("busy_c6_idle", zero_v);

        // strobe held through the idle cycle after a sequence is taken at once
        bus.call = 1'b1;
        tick();
        bus.call = 1'b0;
        chk("b2b_c1", call1_v);
        tick(); chk("b2b_c2", call2_v);
        bus.ret = 1'b1;
        tick();
        chk("b2b_c3_idle", zero_v);
        tick();
        bus.ret = 1'b0;
        chk("b2b_c4_wait", wait_v);
        tick(); chk("b2b_c5_wait", wait_v);
        tick(); chk("b2b_c6_pop2", pop2_v);
        tick(); chk("b2b_c7_pop1", pop1_v);
        tick(); chk("b2b_c8_idle", zero_v);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
